// File: rtl/audio_fx_router.sv
// Frame processor between the I2S receive FIFO and the I2S transmit FIFO.
// It handles one multi-channel frame at a time and applies bypass, gain, mute or mono downmix.
module audio_fx_router #(
    parameter int SAMPLE_W  = 16,
    parameter int NUM_CH    = 2,
    parameter int GAIN_W    = 16,
    parameter int FRAC_BITS = 14
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   mode,
    input  logic [NUM_CH*GAIN_W-1:0]     gain,
    input  logic                         clip_clr,
    input  logic                         src_empty,
    output logic                         src_rd,
    input  logic [NUM_CH*SAMPLE_W-1:0]   src_data,
    input  logic                         dst_full,
    output logic                         dst_wr,
    output logic [NUM_CH*SAMPLE_W-1:0]   dst_data,
    output logic                         busy,
    output logic [NUM_CH-1:0]            clip,
    output logic [31:0]                  frame_cnt
);

    localparam int P_W     = SAMPLE_W + GAIN_W;
    localparam int A_W     = SAMPLE_W + 3;
    localparam int K_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LOG2_CH = $clog2(NUM_CH);

    localparam logic signed [P_W:0] ROUND_C = (P_W+1)'(1) << (FRAC_BITS - 1);
    localparam logic signed [P_W:0] SAT_MAX = {{(P_W-SAMPLE_W+2){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [P_W:0] SAT_MIN = {{(P_W-SAMPLE_W+2){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_CAPTURE, ST_PROC, ST_WRITE} state_t;
    typedef enum logic [1:0] {MODE_BYPASS, MODE_GAIN, MODE_MUTE, MODE_MONO} fx_mode_t;

    state_t                      r_state;
    fx_mode_t                    r_mode;
    logic signed [SAMPLE_W-1:0]  r_in   [NUM_CH];
    logic signed [GAIN_W-1:0]    r_gain [NUM_CH];
    logic signed [SAMPLE_W-1:0]  r_out  [NUM_CH];
    logic signed [A_W-1:0]       r_acc;
    logic [K_W-1:0]              r_k;
    logic                        r_src_rd;
    logic                        r_dst_wr;
    logic                        r_busy;
    logic [NUM_CH-1:0]           r_clip;
    logic [31:0]                 r_frame_cnt;

    logic signed [SAMPLE_W-1:0]  w_in_k;
    logic signed [GAIN_W-1:0]    w_g_k;
    logic signed [P_W-1:0]       w_prod;
    logic signed [P_W:0]         w_q;
    logic                        w_sat_hi;
    logic                        w_sat_lo;
    logic signed [A_W-1:0]       w_acc_next;
    logic signed [SAMPLE_W-1:0]  w_mono;
    logic                        w_last;
    logic signed [SAMPLE_W-1:0]  w_ch_out;
    logic [NUM_CH-1:0]           w_clip_set;

    // NOTE: the frame-local copies have no reset; CAPTURE always writes them before PROC reads them.
    always_ff @(posedge clk) begin
        if (r_state == ST_CAPTURE) begin
            r_mode <= fx_mode_t'(mode);
            for (int i = 0; i < NUM_CH; i++) begin
                r_in[i]   <= src_data[i*SAMPLE_W +: SAMPLE_W];
                r_gain[i] <= gain[i*GAIN_W +: GAIN_W];
            end
        end
    end

    // One shared multiplier, steered by the channel index.
    assign w_in_k     = r_in[r_k];
    assign w_g_k      = r_gain[r_k];
    assign w_prod     = $signed({{GAIN_W{w_in_k[SAMPLE_W-1]}}, w_in_k})
                      * $signed({{SAMPLE_W{w_g_k[GAIN_W-1]}}, w_g_k});
    assign w_q        = ($signed({w_prod[P_W-1], w_prod}) + ROUND_C) >>> FRAC_BITS;
    assign w_sat_hi   = (w_q > SAT_MAX);
    assign w_sat_lo   = (w_q < SAT_MIN);
    assign w_acc_next = r_acc + A_W'(w_in_k);
    assign w_mono     = SAMPLE_W'(w_acc_next >>> LOG2_CH);
    assign w_last     = (r_k == K_W'(NUM_CH - 1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_ch_out   = w_in_k;
        w_clip_set = '0;
        case (r_mode)
            MODE_GAIN: begin
                if (w_sat_hi) begin
                    w_ch_out = {1'b0, {(SAMPLE_W-1){1'b1}}};
                end else if (w_sat_lo) begin
                    w_ch_out = {1'b1, {(SAMPLE_W-1){1'b0}}};
                end else begin
                    w_ch_out = w_q[SAMPLE_W-1:0];
                end
                if (r_state == ST_PROC && (w_sat_hi || w_sat_lo)) begin
                    w_clip_set[r_k] = 1'b1;
                end
            end
            MODE_MUTE: w_ch_out = '0;
            default:   w_ch_out = w_in_k;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_src_rd    <= 1'b0;
            r_dst_wr    <= 1'b0;
            r_busy      <= 1'b0;
            r_clip      <= '0;
            r_frame_cnt <= '0;
            r_acc       <= '0;
            r_k         <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_out[i] <= '0;
            end
        end else begin
            r_src_rd <= 1'b0;
            r_dst_wr <= 1'b0;
            r_clip   <= (clip_clr ? '0 : r_clip) | w_clip_set;
            case (r_state)
                ST_IDLE: begin
                    if (!src_empty) begin
                        r_state  <= ST_READ;
                        r_src_rd <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_READ: r_state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    r_acc   <= '0;
                    r_k     <= '0;
                    r_state <= ST_PROC;
                end
                ST_PROC: begin
                    r_acc      <= w_acc_next;
                    r_out[r_k] <= w_ch_out;
                    if (w_last) begin
                        if (r_mode == MODE_MONO) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                r_out[i] <= w_mono;
                            end
                        end
                        r_state <= ST_WRITE;
                        // The registered strobe is decided a cycle early; only our writes can raise full.
                        if (!dst_full) begin
                            r_dst_wr    <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 32'd1;
                        end
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (r_dst_wr) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!dst_full) begin
                        r_dst_wr    <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign dst_data[g*SAMPLE_W +: SAMPLE_W] = r_out[g];
    end

    assign src_rd    = r_src_rd;
    assign dst_wr    = r_dst_wr;
    assign busy      = r_busy;
    assign clip      = r_clip;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_audio_fx_router.sv
// Scoreboard bench for audio_fx_router with four channels: a source FIFO model feeds frames,
// expected frames are queued at push time and compared on every dst_wr.
module tb_audio_fx_router;

    localparam int SW = 16;
    localparam int NC = 4;
    localparam int GW = 16;
    localparam int FB = 14;
    localparam int DW = SW * NC;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [NC*GW-1:0] gain = '0;
    logic          clip_clr = 1'b0;
    logic          src_empty = 1'b1;
    logic          src_rd;
    logic [DW-1:0] src_data = '0;
    logic          dst_full = 1'b0;
    logic          dst_wr;
    logic [DW-1:0] dst_data;
    logic          busy;
    logic [NC-1:0] clip;
    logic [31:0]   frame_cnt;

    always #5 clk = ~clk;

    audio_fx_router #(
        .SAMPLE_W (SW),
        .NUM_CH   (NC),
        .GAIN_W   (GW),
        .FRAC_BITS(FB)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .gain     (gain),
        .clip_clr (clip_clr),
        .src_empty(src_empty),
        .src_rd   (src_rd),
        .src_data (src_data),
        .dst_full (dst_full),
        .dst_wr   (dst_wr),
        .dst_data (dst_data),
        .busy     (busy),
        .clip     (clip),
        .frame_cnt(frame_cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    time t_rd = 0;
    time t_wr = 0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] f4(input logic [15:0] c0, input logic [15:0] c1,
                                         input logic [15:0] c2, input logic [15:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // Reference model: integer arithmetic on each channel.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] f, input logic [1:0] m,
                                            input logic [NC*GW-1:0] g);
        logic [DW-1:0] r;
        longint p;
        longint sum;
        r   = '0;
        sum = 0;
        case (m)
            2'd0: r = f;
            2'd1: begin
                for (int k = 0; k < NC; k++) begin
                    p = longint'($signed(f[k*SW +: SW])) * longint'($signed(g[k*GW +: GW]));
                    p = (p + (64'sd1 <<< (FB - 1))) >>> FB;
                    if (p > 32767) p = 32767;
                    if (p < -32768) p = -32768;
                    r[k*SW +: SW] = p[SW-1:0];
                end
            end
            2'd2: r = '0;
            default: begin
                for (int k = 0; k < NC; k++) sum += longint'($signed(f[k*SW +: SW]));
                sum = sum >>> 2;
                for (int k = 0; k < NC; k++) r[k*SW +: SW] = sum[SW-1:0];
            end
        endcase
        return r;
    endfunction

    task automatic push_frame(input logic [DW-1:0] f);
        src_q.push_back(f);
        exp_q.push_back(model(f, mode, gain));
    endtask

    // Source FIFO model: data appears the cycle after the read strobe.
    always @(negedge clk) begin
        if (src_rd && src_q.size() != 0) src_data = src_q.pop_front();
        src_empty = (src_q.size() == 0);
    end

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        if (src_rd) begin
            rd_cnt++;
            check("rd_with_wr", 64'(dst_wr), 64'd0);
        end
        if (dst_wr) begin
            wr_cnt++;
            check("wr_while_full", 64'(dst_full), 64'd0);
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("dst_data", dst_data, exp_q.pop_front());
        end
    end

    task automatic wait_rd();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (src_rd) break;
        end
        t_rd = $time;
        if (!src_rd) check("rd_timeout", 64'(src_rd), 64'd1);
    endtask

    task automatic wait_wr();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (dst_wr) break;
        end
        t_wr = $time;
        if (!dst_wr) check("wr_timeout", 64'(dst_wr), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && src_q.size() == 0) break;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int wr0;
        logic [DW-1:0] fa;

        repeat (3) @(negedge clk);
        check("rst_src_rd", 64'(src_rd), 64'd0);
        check("rst_dst_wr", 64'(dst_wr), 64'd0);
        check("rst_dst_data", dst_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_clip", 64'(clip), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Bypass with latency and single-read checks.
        rd0 = rd_cnt;
        push_frame(f4(16'hABCD, 16'h1234, 16'h8001, 16'h5A5A));
        wait_rd();
        wait_wr();
        check("bp_latency", 64'((t_wr - t_rd) / 10), 64'(NC + 2));
        check("bp_rd_once", 64'(rd_cnt - rd0), 64'd1);
        @(negedge clk);
        check("bp_busy_after", 64'(busy), 64'd0);
        check("bp_frame_cnt", 64'(frame_cnt), 64'd1);
        check("bp_data", dst_data, 64'h5A5A_8001_1234_ABCD);

        // Gain with round-half-up, including 0.5 * -3.
        mode = 2'd1;
        gain = f4(16'h6000, 16'h6000, 16'h6000, 16'h2000);
        push_frame(f4(16'h4000, 16'h0003, 16'h0100, 16'hFFFD));
        wait_idle(64);
        check("gain_data", dst_data, 64'hFFFF_0180_0005_6000);
        check("gain_clip", 64'(clip), 64'd0);

        // Saturation at both rails.
        gain = f4(16'h6000, 16'h6000, 16'h6000, 16'h6000);
        push_frame(f4(16'h7000, 16'h9000, 16'h0001, 16'hFFFF));
        wait_idle(64);
        check("sat_data", dst_data, 64'hFFFF_0002_8000_7FFF);
        check("sat_clip", 64'(clip), 64'b0011);

        // clip_clr in the same cycle as a new saturation on channel 0.
        push_frame(f4(16'h7000, 16'h0000, 16'h0000, 16'h0000));
        wait_rd();
        @(negedge clk);
        @(negedge clk);
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        wait_idle(64);
        check("clr_vs_set_clip", 64'(clip), 64'b0001);
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        @(negedge clk);
        check("clr_alone_clip", 64'(clip), 64'd0);

        // Backpressure: frame held in WRITE for ten cycles, second frame waiting.
        mode     = 2'd0;
        dst_full = 1'b1;
        rd0      = rd_cnt;
        wr0      = wr_cnt;
        fa       = {$urandom, $urandom};
        push_frame(fa);
        push_frame({$urandom, $urandom});
        wait_rd();
        repeat (NC + 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("stall_wr", 64'(dst_wr), 64'd0);
            check("stall_data", dst_data, fa);
            @(negedge clk);
        end
        dst_full = 1'b0;
        wait_wr();
        check("stall_one_rd", 64'(rd_cnt - rd0), 64'd1);
        wait_idle(64);
        check("stall_wr_cnt", 64'(wr_cnt - wr0), 64'd2);

        // Mono downmix and mute.
        mode = 2'd3;
        push_frame(f4(16'd100, 16'd200, 16'hFFCE, 16'd7));
        wait_idle(64);
        check("mono_data", dst_data, 64'h0040_0040_0040_0040);
        mode = 2'd2;
        push_frame({$urandom, $urandom});
        wait_idle(64);
        check("mute_data", dst_data, 64'd0);

        // Mode change during PROC must not affect the captured frame.
        mode = 2'd3;
        push_frame(f4(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC));
        wait_rd();
        @(negedge clk);
        @(negedge clk);
        mode = 2'd2;
        wait_idle(64);
        check("mode_chg_data", dst_data, 64'hFFFD_FFFD_FFFD_FFFD);

        // Reset asserted during PROC discards the frame in flight.
        mode = 2'd0;
        push_frame({$urandom, $urandom});
        wait_rd();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_src_rd", 64'(src_rd), 64'd0);
        check("midrst_dst_wr", 64'(dst_wr), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        void'(exp_q.pop_back());
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back stream of 1000 frames through the gain path.
        mode = 2'd1;
        for (int k = 0; k < NC; k++) gain[k*GW +: GW] = 16'($urandom_range(0, 16'hFFFF));
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        for (int n = 0; n < 1000; n++) push_frame({$urandom, $urandom});
        wait_idle(1000 * (NC + 4) + 200);
        check("stream_frame_cnt", 64'(frame_cnt), 64'd1000);
        check("stream_rd_cnt", 64'(rd_cnt - rd0), 64'd1000);
        check("stream_wr_cnt", 64'(wr_cnt - wr0), 64'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
